uart_msg_sequencer: RTL and testbench
=====================================

Name: uart_msg_sequencer

Overview:
Parametrised message sequencer between the colour-detection front end and the UART transmitter.
- Turns one-hot colour events on N_CH channels into fixed-length ASCII status messages from a parameter table, with an optional terminator byte appended.
- Drives per-channel indicator LEDs.
- Queues events in a small FIFO so colour changes arriving mid-transmission are not lost.
- Talks to the UART byte transmitter through a valid/ready handshake.

Parameters:
- N_CH, 3: number of colour channels; width of color_in and led.
- MSG_LEN, 11: message length in characters, terminator excluded.
- MSG_TABLE, {"SI-SIM2-N-#","SI-SIM3-W-#","SI-SIM1-P-#"}: N_CH*MSG_LEN*8 bits. Channel 0 occupies the LSB slice; within a slice the MSB byte is sent first.
- APPEND_TERM, 1: 1 appends TERM_CHAR after each message.
- TERM_CHAR, 8'h0D: terminator byte.
- QDEPTH, 4: event FIFO depth; power of 2, minimum 2.
- MODE, 0: 0 = send only when the colour differs from the last enqueued colour; 1 = send on every transition into a valid colour, including from no-colour.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_detecting_color  in  1  enable for event capture and LEDs.
- color_in  in  N_CH  one-hot colour code; all-zero means no colour.
- tx_ready  in  1  UART can accept a byte this cycle.
- tx_data_valid  out  1  tx_byte is valid.
- tx_byte  out  8  byte to transmit.
- led  out  N_CH  registered one-hot LED drive.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- msg_done  out  1  one-cycle pulse when the last byte of a message is accepted.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset, sampled on clk: tx_data_valid, tx_byte, led, busy, msg_done and overflow all go to 0. FIFO is emptied, last_color is 0, FSM goes to IDLE.
- Reset during a message aborts it; tx_data_valid is low from the following cycle.
- Colour sampling:
  - color_in is registered into col_q every cycle.
  - valid_col = col_q is non-zero and has exactly one bit set. Multi-hot values are ignored: no event, no LED change.
- LEDs:
  - When start_detecting_color is 1 and valid_col: led <= col_q.
  - When col_q is zero or start_detecting_color is 0: led <= 0.
  - Multi-hot col_q: led holds its value.
- Event generation (only while start_detecting_color is 1):
  - MODE 0: event when valid_col and col_q != last_color. last_color updates on every enqueue attempt and holds through no-colour periods.
  - MODE 1: event when valid_col and col_q differs from the previous cycle's col_q.
- FIFO:
  - Stores the channel index, width clog2(N_CH).
  - Event with FIFO full: event dropped, overflow set, and last_color still updated.
  - Push and pop in the same cycle are both honoured.
- FSM states and transitions:
  - IDLE: if FIFO is not empty, go to LOAD.
  - LOAD: pop FIFO, latch idx, byte_cnt <= 0, go to SEND.
  - SEND:
    - tx_data_valid = 1 and tx_byte = byte[byte_cnt] of slice idx; byte_cnt MSLAST = MSG_LEN-1+APPEND_TERM.
    - tx_byte and tx_data_valid hold stable while tx_ready is 0.
    - Byte accepted when tx_data_valid and tx_ready are high in the same cycle.
    - On accept with byte_cnt < LAST: byte_cnt++, next byte presented the next cycle, with no idle gap.
    - On accept with byte_cnt == LAST: msg_done pulses, tx_data_valid drops, go to IDLE.
- Latency: with FSM in IDLE and FIFO empty, tx_data_valid rises 3 edges after the edge that registers a new colour into col_q (push, LOAD, SEND).
- Dropping start_detecting_color:
  - Stops new events and clears led.
  - The in-flight message and any queued messages still complete.
- byte_cnt width is clog2(MSG_LEN+1); it never exceeds LAST.
- busy = (state != IDLE) | FIFO not empty.

Test Plan:
- Reset, then color_in=3'b001 with start high, tx_ready tied 1:
  - 12 bytes "SI-SIM1-P-#",0x0D go out on consecutive cycles.
  - tx_data_valid first high 3 edges after capture.
  - led=001.
  - msg_done pulses on the 0x0D accept.
- tx_ready toggling 1/0 every cycle: every byte stays stable while stalled; the sequence is identical to the previous case.
- MODE 0, color 001 → 000 → 001: only one message sent. MODE 1, same stimulus: two messages sent.
- QDEPTH=4, colours 001,010,100,001,010,100 while tx_ready=0:
  - First event enters SEND; the next 4 are queued; the 6th is dropped and overflow=1.
  - After release, messages go out in order SIM1, SIM3, SIM2, SIM1, SIM3.
- color_in=3'b011: no event and led unchanged. Then start_detecting_color=0 mid-message: the message completes and led=0.
- rst asserted at byte 5: tx_data_valid=0 the next cycle, FIFO empty, busy=0; color 010 afterwards sends the full "SI-SIM3-W-#",0x0D.

Source files
------------

// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: turns one-hot colour events into queued fixed-length ASCII messages
// and streams them byte by byte to a UART transmitter over a valid/ready handshake.
module uart_msg_sequencer #(
    parameter int N_CH = 3,
    parameter int MSG_LEN = 11,
    parameter logic [N_CH*MSG_LEN*8-1:0] MSG_TABLE = {"SI-SIM2-N-#", "SI-SIM3-W-#", "SI-SIM1-P-#"},
    parameter int APPEND_TERM = 1,
    parameter logic [7:0] TERM_CHAR = 8'h0D,
    parameter int QDEPTH = 4,
    parameter int MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_detecting_color,
    input  logic [N_CH-1:0] color_in,
    input  logic            tx_ready,
    output logic            tx_data_valid,
    output logic [7:0]      tx_byte,
    output logic [N_CH-1:0] led,
    output logic            busy,
    output logic            msg_done,
    output logic            overflow
);
    localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(MSG_LEN + 1);
    localparam int LAST = MSG_LEN - 1 + APPEND_TERM;
    localparam logic [CW-1:0] LAST_C = CW'(LAST);
    localparam logic [AW:0] QFULL = (AW + 1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t state, state_n;

    logic [N_CH-1:0] col_q, prev_col, last_color;
    logic            valid_col, evt, full, push, pop, accept;
    logic [IW-1:0]   ch, idx;
    logic [IW-1:0]   mem [QDEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      rom [N_CH][MSG_LEN];

    // rom[c][b] is byte b (send order) of channel c's message
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        for (genvar b = 0; b < MSG_LEN; b++) begin : g_b
            assign rom[c][b] = MSG_TABLE[(c*MSG_LEN + MSG_LEN - 1 - b)*8 +: 8];
        end
    end

    assign valid_col = $onehot(col_q);
    assign evt = start_detecting_color && valid_col &&
                 (MODE == 1 ? col_q != prev_col : col_q != last_color);
    assign full = count == QFULL;
    assign push = evt && !full;
    assign pop = state == LOAD;
    assign accept = state == SEND && tx_ready;

    always_comb begin
        ch = '0;
        for (int i = 0; i < N_CH; i++)
            if (col_q[i]) ch = IW'(i);
    end

    // multi-hot samples leave the LEDs untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            prev_col <= '0;
            last_color <= '0;
            led <= '0;
        end else begin
            col_q <= color_in;
            prev_col <= col_q;
            if (evt) last_color <= col_q;
            if (start_detecting_color && valid_col) led <= col_q;
            else if (!start_detecting_color || col_q == '0) led <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (evt && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && count != '0) state_n = LOAD;
        else if (state == LOAD) state_n = SEND;
        else if (accept && byte_cnt == LAST_C) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            byte_cnt <= '0;
        end else if (state == LOAD) begin
            idx <= mem[rd_ptr];
            byte_cnt <= '0;
        end else if (accept && byte_cnt != LAST_C) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    always_comb begin
        tx_data_valid = state == SEND;
        msg_done = accept && byte_cnt == LAST_C;
        busy = state != IDLE || count != '0;
        tx_byte = !tx_data_valid ? 8'h00 :
                  (APPEND_TERM != 0 && byte_cnt == LAST_C) ? TERM_CHAR : rom[idx][byte_cnt];
    end
endmodule

// File: tb/tb_uart_msg_sequencer.sv
// tb_uart_msg_sequencer: directed bench for uart_msg_sequencer; a MODE 1 instance
// shares the stimulus so the two event policies can be contrasted.
module tb_uart_msg_sequencer;
    logic clk = 0, rst = 1, start_detecting_color = 0, tx_ready = 0;
    logic [2:0] color_in = 0;
    logic tx_data_valid, busy, msg_done, overflow;
    logic [7:0] tx_byte;
    logic [2:0] led;
    logic tx_data_valid1, busy1, msg_done1, overflow1;
    logic [7:0] tx_byte1;
    logic [2:0] led1;
    int n_cmp = 0, n_err = 0, cyc = 0, dones = 0, dones1 = 0;
    int acc_first = 0, acc_last = 0, d0 = 0, d1 = 0;
    logic [7:0] rx [$];
    logic [7:0] done_byte = 0, stall_b = 0;
    logic stall_q = 0;
    logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    always #5 clk = ~clk;

    uart_msg_sequencer dut (
        .clk(clk), .rst(rst), .start_detecting_color(start_detecting_color),
        .color_in(color_in), .tx_ready(tx_ready), .tx_data_valid(tx_data_valid),
        .tx_byte(tx_byte), .led(led), .busy(busy), .msg_done(msg_done), .overflow(overflow)
    );

    uart_msg_sequencer #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .start_detecting_color(start_detecting_color),
        .color_in(color_in), .tx_ready(tx_ready), .tx_data_valid(tx_data_valid1),
        .tx_byte(tx_byte1), .led(led1), .busy(busy1), .msg_done(msg_done1), .overflow(overflow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: monitor at the falling edge, return 1 time unit after the rising edge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (stall_q) begin
            chk("stall_valid", tx_data_valid, 1);
            chk("stall_byte", tx_byte, stall_b);
        end
        stall_q = tx_data_valid & ~tx_ready;
        stall_b = tx_byte;
        if (tx_data_valid && tx_ready) begin
            if (rx.size() == 0) acc_first = cyc;
            acc_last = cyc;
            rx.push_back(tx_byte);
        end
        if (msg_done) begin
            dones++;
            done_byte = tx_byte;
        end
        if (msg_done1) dones1++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input bit tog);
        for (int i = 0; i < 400 && dones < target; i++) begin
            if (tog) tx_ready = ~tx_ready;
            step();
        end
        chk("msg_done_count", dones, target);
    endtask

    task automatic check_msg(input string s);
        logic [7:0] b;
        for (int i = 0; i < s.len(); i++) begin
            b = rx.size() > 0 ? rx.pop_front() : 8'hxx;
            chk($sformatf("%s[%0d]", s, i), b, s[i]);
        end
        b = rx.size() > 0 ? rx.pop_front() : 8'hxx;
        chk($sformatf("%s[term]", s), b, 8'h0D);
    endtask

    task automatic pulse_rst();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", msg_done, 0);
        chk("rst_ovf", overflow, 0);

        rst = 0;
        start_detecting_color = 1;
        tx_ready = 1;
        color_in = 3'b001;
        step();
        step();
        chk("led_001", led, 3'b001);
        chk("busy_queued", busy, 1);
        chk("valid_e1", tx_data_valid, 0);
        step();
        chk("valid_e2", tx_data_valid, 0);
        step();
        chk("valid_e3", tx_data_valid, 1);
        chk("first_byte", tx_byte, 8'h53);
        wait_done(1, 0);
        chk("len_sim1", rx.size(), 12);
        chk("span_ready1", acc_last - acc_first, 11);
        chk("done_on_term", done_byte, 8'h0D);
        check_msg("SI-SIM1-P-#");
        chk("idle_busy", busy, 0);
        chk("idle_valid", tx_data_valid, 0);

        pulse_rst();
        wait_done(2, 1);
        tx_ready = 1;
        chk("len_toggle", rx.size(), 12);
        chk("span_toggle", acc_last - acc_first, 22);
        check_msg("SI-SIM1-P-#");

        d0 = dones;
        d1 = dones1;
        color_in = 3'b000;
        step();
        step();
        chk("led_nocolour", led, 0);
        step();
        color_in = 3'b001;
        repeat (40) step();
        chk("mode0_no_resend", dones, d0);
        chk("mode0_no_bytes", rx.size(), 0);
        chk("mode1_resend", dones1, d1 + 1);

        pulse_rst();
        tx_ready = 0;
        for (int i = 0; i < 6; i++) begin
            color_in = seq[i];
            repeat (3) step();
        end
        chk("ovf_set", overflow, 1);
        chk("ovf1_set", overflow1, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_stalled_valid", tx_data_valid, 1);
        chk("ovf_stalled_byte", tx_byte, 8'h53);
        tx_ready = 1;
        d0 = dones;
        wait_done(d0 + 5, 0);
        chk("len_five", rx.size(), 60);
        check_msg("SI-SIM1-P-#");
        check_msg("SI-SIM3-W-#");
        check_msg("SI-SIM2-N-#");
        check_msg("SI-SIM1-P-#");
        check_msg("SI-SIM3-W-#");
        chk("ovf_sticky", overflow, 1);

        color_in = 3'b011;
        repeat (3) step();
        chk("multihot_led", led, 3'b100);
        chk("multihot_busy", busy, 0);
        d0 = dones;
        color_in = 3'b010;
        repeat (4) step();
        chk("mid_valid", tx_data_valid, 1);
        chk("led_010", led, 3'b010);
        start_detecting_color = 0;
        step();
        chk("led_cleared", led, 0);
        wait_done(d0 + 1, 0);
        chk("len_drop", rx.size(), 12);
        check_msg("SI-SIM3-W-#");
        chk("drop_busy", busy, 0);

        start_detecting_color = 1;
        color_in = 3'b100;
        d0 = dones;
        for (int i = 0; i < 100 && rx.size() < 5; i++) step();
        chk("five_bytes", rx.size(), 5);
        rst = 1;
        step();
        chk("abort_valid", tx_data_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_byte", tx_byte, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_no_done", dones, d0);
        rx.delete();
        rst = 0;
        color_in = 3'b010;
        wait_done(d0 + 1, 0);
        chk("len_after_rst", rx.size(), 12);
        check_msg("SI-SIM3-W-#");
        chk("mode1_valid_end", tx_data_valid1, 0);
        chk("mode1_byte_end", tx_byte1, 0);
        chk("mode1_busy_end", busy1, 0);
        chk("mode1_led_end", led1, 3'b010);
        chk("mode1_ovf_end", overflow1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
